// File: rtl/debug_dump_tx_if.sv
// debug_dump_tx_if
// Groups the three handshakes of the debug-dump transmitter:
//   request      : start, sel (in)  / busy, done (out)
//   read port    : rd_src, rd_addr (out) / rd_data (in, 1-cycle latency)
//   UART TX      : tx_start, tx_data (out) / tx_done_tick (in)
// The master modport is the transmitter; the slave modport is the
// environment (command FSM, datapath read port and UART together).
interface debug_dump_tx_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
);
  logic               start;
  logic [1:0]         sel;
  logic               busy;
  logic               done;
  logic [1:0]         rd_src;
  logic [NB_ADDR-1:0] rd_addr;
  logic [NB_DATA-1:0] rd_data;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_done_tick;

  modport master (
    input  start, sel, rd_data, tx_done_tick,
    output busy, done, rd_src, rd_addr, tx_start, tx_data
  );

  modport slave (
    output start, sel, rd_data, tx_done_tick,
    input  busy, done, rd_src, rd_addr, tx_start, tx_data
  );
endinterface

// File: rtl/debug_dump_tx.sv
// debug_dump_tx
// Streams the PC, the register bank and the data memory to the UART
// transmitter, one byte per tx_start/tx_done_tick handshake, least
// significant byte of each word first. A request dumps one source or all
// three back-to-back (PC, BR, MEM) and may be followed by an XOR checksum
// of every data byte sent.
// Ports:
//   i_clock        rising-edge clock
//   i_reset        synchronous, active-high reset
//   bus (master)   start/sel request and busy/done status,
//                  rd_src/rd_addr/rd_data datapath read port,
//                  tx_start/tx_data/tx_done_tick UART byte handshake
module debug_dump_tx #(
  parameter int NB_DATA     = 32,
  parameter int N_REGS      = 32,
  parameter int N_MEM       = 128,
  parameter int NB_ADDR     = 8,
  parameter int EN_CHECKSUM = 1
) (
  input logic             i_clock,
  input logic             i_reset,
  debug_dump_tx_if.master bus
);

  localparam int NB_BYTES = NB_DATA / 8;
  localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NB_BYTES - 1);
  localparam logic [NB_ADDR-1:0] LAST_REG  = NB_ADDR'(N_REGS - 1);
  localparam logic [NB_ADDR-1:0] LAST_MEM  = NB_ADDR'(N_MEM - 1);

  localparam logic [1:0] SRC_PC  = 2'd0;
  localparam logic [1:0] SRC_BR  = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;
  localparam logic [1:0] SEL_ALL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_SEND,
    S_WAIT_TX,
    S_CKSUM,
    S_CK_WAIT,
    S_DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [1:0]         sel_q;
  logic [1:0]         src_q;
  logic [1:0]         first_src;
  logic [NB_ADDR-1:0] word_cnt;
  logic [NB_ADDR-1:0] last_word;
  logic [NB_BCNT-1:0] byte_cnt;
  logic [NB_DATA-1:0] word_q;
  logic [7:0]         cksum_q;
  logic [7:0]         tx_hold;
  logic               more_bytes;
  logic               more_words;
  logic               more_srcs;

  // Source selected by the request; ALL starts with the PC.
  always_comb begin
    case (bus.sel)
      2'd1:    first_src = SRC_BR;
      2'd2:    first_src = SRC_MEM;
      default: first_src = SRC_PC;
    endcase
  end

  always_comb begin
    case (src_q)
      SRC_BR:  last_word = LAST_REG;
      SRC_MEM: last_word = LAST_MEM;
      default: last_word = '0;
    endcase
  end

  // Counters start at zero and never pass their last value, so an
  // inequality is enough to tell whether more remain.
  assign more_bytes = (byte_cnt != LAST_BYTE);
  assign more_words = (word_cnt != last_word);
  assign more_srcs  = (sel_q == SEL_ALL) && (src_q != SRC_MEM);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // tx_done_tick is only looked at in the two wait states, so a tick that
  // coincides with tx_start (SEND/CKSUM) cannot skip a byte.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          next_state = S_FETCH;
        end
      end
      S_FETCH: next_state = S_LATCH;
      S_LATCH: next_state = S_SEND;
      S_SEND:  next_state = S_WAIT_TX;
      S_WAIT_TX: begin
        if (bus.tx_done_tick) begin
          if (more_bytes) begin
            next_state = S_SEND;
          end else if (more_words || more_srcs) begin
            next_state = S_FETCH;
          end else if (EN_CHECKSUM != 0) begin
            next_state = S_CKSUM;
          end else begin
            next_state = S_DONE;
          end
        end
      end
      S_CKSUM: next_state = S_CK_WAIT;
      S_CK_WAIT: begin
        if (bus.tx_done_tick) begin
          next_state = S_DONE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Word/byte/source bookkeeping. The word register is shifted right after
  // each byte so the byte to send is always word_q[7:0]. tx_hold keeps the
  // last transmitted byte visible between SEND/CKSUM cycles.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sel_q    <= '0;
      src_q    <= SRC_PC;
      word_cnt <= '0;
      byte_cnt <= '0;
      word_q   <= '0;
      cksum_q  <= '0;
      tx_hold  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            sel_q    <= bus.sel;
            src_q    <= first_src;
            word_cnt <= '0;
            byte_cnt <= '0;
            cksum_q  <= '0;
          end
        end
        S_LATCH: begin
          word_q <= bus.rd_data;
        end
        S_SEND: begin
          cksum_q <= cksum_q ^ word_q[7:0];
          tx_hold <= word_q[7:0];
        end
        S_WAIT_TX: begin
          if (bus.tx_done_tick) begin
            if (more_bytes) begin
              word_q   <= word_q >> 8;
              byte_cnt <= byte_cnt + NB_BCNT'(1);
            end else if (more_words) begin
              word_cnt <= word_cnt + NB_ADDR'(1);
              byte_cnt <= '0;
            end else if (more_srcs) begin
              src_q    <= src_q + 2'd1;
              word_cnt <= '0;
              byte_cnt <= '0;
            end
          end
        end
        S_CKSUM: begin
          tx_hold <= cksum_q;
        end
        default: begin
        end
      endcase
    end
  end

  // The read address is a pure function of src_q/word_cnt, which only change
  // on the way into FETCH, so it holds from one FETCH to the next.
  always_comb begin
    bus.tx_start = 1'b0;
    bus.tx_data  = tx_hold;
    bus.busy     = (state != S_IDLE) && (state != S_DONE);
    bus.done     = (state == S_DONE);
    bus.rd_src   = src_q;
    bus.rd_addr  = (src_q == SRC_PC) ? '0 : word_cnt;
    if (state == S_SEND) begin
      bus.tx_start = 1'b1;
      bus.tx_data  = word_q[7:0];
    end else if (state == S_CKSUM) begin
      bus.tx_start = 1'b1;
      bus.tx_data  = cksum_q;
    end
  end

endmodule

// File: tb/tb_debug_dump_tx.sv
// tb_debug_dump_tx
// Two instances: dut_a with default parameters (32-bit words, checksum on)
// and dut_b with 16-bit words, 4 memory words and no checksum. Each has a
// read-port model with one cycle of latency, a UART model that answers
// every tx_start with tx_done_tick about 100 ns later, and a monitor that
// pops the expected byte (and its read source/address) from a queue.
module tb_debug_dump_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  debug_dump_tx_if #(.NB_DATA(32), .NB_ADDR(8)) ifa ();
  debug_dump_tx_if #(.NB_DATA(16), .NB_ADDR(8)) ifb ();

  debug_dump_tx #(
    .NB_DATA(32), .N_REGS(32), .N_MEM(128), .NB_ADDR(8), .EN_CHECKSUM(1)
  ) dut_a (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (ifa.master)
  );

  debug_dump_tx #(
    .NB_DATA(16), .N_REGS(32), .N_MEM(4), .NB_ADDR(8), .EN_CHECKSUM(0)
  ) dut_b (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (ifb.master)
  );

  int n_checks = 0;
  int n_bad    = 0;

  typedef struct {
    logic [7:0] b;
    logic [1:0] src;
    logic [7:0] addr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  logic [7:0] ck_model;

  logic [31:0] pc_val;
  logic [31:0] regs[32];
  logic [31:0] mem[128];
  logic [15:0] mem_b[4];

  int  starts_a = 0, starts_b = 0, done_a = 0, done_b = 0;
  int  last_txd_a = 0, last_txd_b = 0;
  int  cnt_a = 0, cnt_b = 0;
  bit  abuse_a = 1'b0;

  function automatic logic [31:0] lookup_a(input logic [1:0] s, input logic [7:0] a);
    case (s)
      2'd0:    return pc_val;
      2'd1:    return (a < 8'd32) ? regs[a[4:0]] : 32'hDEADBEEF;
      2'd2:    return (a < 8'd128) ? mem[a[6:0]] : 32'hDEADBEEF;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic logic [15:0] lookup_b(input logic [1:0] s, input logic [7:0] a);
    if (s == 2'd2 && a < 8'd4) return mem_b[a[1:0]];
    return 16'hDEAD;
  endfunction

  // Read ports: data for the address seen at one negedge appears at the next.
  logic [1:0] ps_a, ps_b;
  logic [7:0] pa_a, pa_b;
  initial begin
    ifa.rd_data = '0; ifb.rd_data = '0;
    ps_a = '0; pa_a = '0; ps_b = '0; pa_b = '0;
    forever begin
      @(negedge clk);
      ifa.rd_data = lookup_a(ps_a, pa_a);
      ifb.rd_data = lookup_b(ps_b, pa_b);
      ps_a = ifa.rd_src; pa_a = ifa.rd_addr;
      ps_b = ifb.rd_src; pa_b = ifb.rd_addr;
    end
  end

  // UART models: tx_done_tick 9 negedges after tx_start; abuse_a also
  // raises it in the tx_start cycle itself.
  initial begin
    ifa.tx_done_tick = 1'b0; ifb.tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      ifa.tx_done_tick = 1'b0;
      if (cnt_a > 0) begin
        cnt_a--;
        if (cnt_a == 0) begin ifa.tx_done_tick = 1'b1; last_txd_a = cyc; end
      end
      if (ifa.tx_start === 1'b1) begin
        cnt_a = 9;
        if (abuse_a) ifa.tx_done_tick = 1'b1;
      end
      ifb.tx_done_tick = 1'b0;
      if (cnt_b > 0) begin
        cnt_b--;
        if (cnt_b == 0) begin ifb.tx_done_tick = 1'b1; last_txd_b = cyc; end
      end
      if (ifb.tx_start === 1'b1) cnt_b = 9;
    end
  end

  // Scoreboard monitors.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ifa.tx_start === 1'b1) begin
        starts_a++;
        n_checks++;
        if (q_a.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL a_extra_byte got=%02h expected=no byte", ifa.tx_data);
        end else begin
          e = q_a.pop_front();
          if (ifa.tx_data !== e.b) begin
            n_bad++;
            $display("[TB] FAIL a_byte%0d got=%02h expected=%02h", starts_a, ifa.tx_data, e.b);
          end
          n_checks++;
          if (ifa.rd_src !== e.src || ifa.rd_addr !== e.addr) begin
            n_bad++;
            $display("[TB] FAIL a_rd_port byte%0d got=%0d/%0d expected=%0d/%0d",
                     starts_a, ifa.rd_src, ifa.rd_addr, e.src, e.addr);
          end
        end
      end
      if (ifa.done === 1'b1) done_a++;
      if (ifb.tx_start === 1'b1) begin
        starts_b++;
        n_checks++;
        if (q_b.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL b_extra_byte got=%02h expected=no byte", ifb.tx_data);
        end else begin
          e = q_b.pop_front();
          if (ifb.tx_data !== e.b || ifb.rd_addr !== e.addr || ifb.rd_src !== e.src) begin
            n_bad++;
            $display("[TB] FAIL b_byte%0d got=%02h@%0d expected=%02h@%0d",
                     starts_b, ifb.tx_data, ifb.rd_addr, e.b, e.addr);
          end
        end
      end
      if (ifb.done === 1'b1) done_b++;
    end
  end

  task automatic push_word_a(input logic [1:0] src, input int addr, input logic [31:0] w);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.b = w[8*i +: 8]; e.src = src; e.addr = 8'(addr);
      ck_model = ck_model ^ e.b;
      q_a.push_back(e);
    end
  endtask

  task automatic push_dump_a(input logic [1:0] sel);
    exp_t e;
    q_a.delete();
    ck_model = '0;
    if (sel == 2'd0 || sel == 2'd3) push_word_a(2'd0, 0, pc_val);
    if (sel == 2'd1 || sel == 2'd3) for (int k = 0; k < 32; k++) push_word_a(2'd1, k, regs[k]);
    if (sel == 2'd2 || sel == 2'd3) for (int k = 0; k < 128; k++) push_word_a(2'd2, k, mem[k]);
    e.b = ck_model;
    e.src  = (sel == 2'd0) ? 2'd0 : (sel == 2'd1) ? 2'd1 : 2'd2;
    e.addr = (sel == 2'd0) ? 8'd0 : (sel == 2'd1) ? 8'd31 : 8'd127;
    q_a.push_back(e);
  endtask

  task automatic run_dump_a(input logic [1:0] sel, input bit poke_start, input string name);
    int c0, s0, n_exp;
    bit seen;
    push_dump_a(sel);
    n_exp = q_a.size();
    s0 = starts_a;
    @(negedge clk);
    ifa.sel = sel; ifa.start = 1'b1; c0 = cyc;
    @(negedge clk);
    ifa.start = 1'b0; ifa.sel = ~sel;
    n_checks++;
    if (ifa.busy !== 1'b1) begin
      n_bad++; $display("[TB] FAIL %s_busy got=%b expected=1", name, ifa.busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (ifa.tx_start === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || cyc - c0 != 3) begin
      n_bad++; $display("[TB] FAIL %s_first_latency got=%0d expected=3", name, cyc - c0);
    end
    if (poke_start) begin
      repeat (30) @(negedge clk);
      ifa.sel = 2'd0; ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (ifa.done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_bad++; $display("[TB] FAIL %s_done_timeout got=no done expected=done", name);
    end else begin
      n_checks++;
      if (cyc - last_txd_a != 1) begin
        n_bad++; $display("[TB] FAIL %s_done_latency got=%0d expected=1", name, cyc - last_txd_a);
      end
    end
    n_checks++;
    if (starts_a - s0 != n_exp) begin
      n_bad++; $display("[TB] FAIL %s_byte_count got=%0d expected=%0d", name, starts_a - s0, n_exp);
    end
    n_checks++;
    if (q_a.size() != 0) begin
      n_bad++; $display("[TB] FAIL %s_leftover got=%0d expected=0", name, q_a.size());
    end
    @(negedge clk);
    n_checks++;
    if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
      n_bad++; $display("[TB] FAIL %s_after_done busy/done got=%b/%b expected=0/0", name, ifa.busy, ifa.done);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (ifa.tx_start !== 1'b0 || ifa.tx_data !== 8'h00 || ifa.busy !== 1'b0 ||
        ifa.done !== 1'b0 || ifa.rd_src !== 2'd0 || ifa.rd_addr !== 8'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_a got=%b %02h %b %b %0d %0d expected=0 00 0 0 0 0",
               ifa.tx_start, ifa.tx_data, ifa.busy, ifa.done, ifa.rd_src, ifa.rd_addr);
    end
    n_checks++;
    if (ifb.tx_start !== 1'b0 || ifb.busy !== 1'b0 || ifb.done !== 1'b0 || ifb.tx_data !== 8'h00) begin
      n_bad++;
      $display("[TB] FAIL reset_b got=%b %b %b %02h expected=0 0 0 00",
               ifb.tx_start, ifb.busy, ifb.done, ifb.tx_data);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ifa.busy !== 1'b0 || ifa.tx_start !== 1'b0) begin
      n_bad++; $display("[TB] FAIL idle_after_reset got=%b/%b expected=0/0", ifa.busy, ifa.tx_start);
    end
  endtask

  task automatic test_pc_dump();
    pc_val = 32'h0000002C;
    run_dump_a(2'd0, 1'b0, "pc");
  endtask

  task automatic test_br_dump();
    run_dump_a(2'd1, 1'b0, "br");
  endtask

  task automatic test_all_dump();
    pc_val = 32'h00000028;
    mem[1] = 32'h0000001E;
    run_dump_a(2'd3, 1'b0, "all");
    mem[1] = 32'h0;
  endtask

  task automatic test_tx_done_same_cycle();
    pc_val = 32'hA1B2C3D4;
    abuse_a = 1'b1;
    run_dump_a(2'd0, 1'b0, "abuse_done");
    abuse_a = 1'b0;
  endtask

  task automatic test_start_while_busy();
    run_dump_a(2'd1, 1'b1, "busy_start");
  endtask

  task automatic test_reset_mid_dump();
    int n, s, d;
    push_dump_a(2'd1);
    @(negedge clk);
    ifa.sel = 2'd1; ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    n = 0;
    for (int i = 0; i < 2000 && n < 10; i++) begin
      @(negedge clk);
      if (ifa.tx_start === 1'b1) n++;
    end
    n_checks++;
    if (n != 10) begin
      n_bad++; $display("[TB] FAIL midrst_reach got=%0d expected=10", n);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q_a.delete();
    n_checks++;
    if (ifa.busy !== 1'b0 || ifa.tx_start !== 1'b0 || ifa.tx_data !== 8'h00 ||
        ifa.rd_src !== 2'd0 || ifa.rd_addr !== 8'd0 || ifa.done !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL midrst_outputs got=%b %b %02h %0d %0d %b expected=0 0 00 0 0 0",
               ifa.busy, ifa.tx_start, ifa.tx_data, ifa.rd_src, ifa.rd_addr, ifa.done);
    end
    s = starts_a; d = done_a;
    repeat (40) @(negedge clk);
    n_checks++;
    if (starts_a != s || done_a != d) begin
      n_bad++; $display("[TB] FAIL midrst_quiet starts/done got=%0d/%0d expected=0/0", starts_a - s, done_a - d);
    end
    pc_val = 32'h0000002C;
    run_dump_a(2'd0, 1'b0, "after_rst");
  endtask

  task automatic test_narrow_no_checksum();
    exp_t e;
    int s0;
    bit seen;
    q_b.delete();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 2; i++) begin
        e.b = mem_b[k][8*i +: 8]; e.src = 2'd2; e.addr = 8'(k);
        q_b.push_back(e);
      end
    end
    s0 = starts_b;
    @(negedge clk);
    ifb.sel = 2'd2; ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (ifb.done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_bad++; $display("[TB] FAIL narrow_done_timeout got=no done expected=done");
    end else begin
      n_checks++;
      if (cyc - last_txd_b != 1) begin
        n_bad++; $display("[TB] FAIL narrow_done_latency got=%0d expected=1", cyc - last_txd_b);
      end
    end
    n_checks++;
    if (starts_b - s0 != 8 || q_b.size() != 0) begin
      n_bad++; $display("[TB] FAIL narrow_count got=%0d left=%0d expected=8 left=0", starts_b - s0, q_b.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    ifa.start = 1'b0; ifa.sel = 2'd0;
    ifb.start = 1'b0; ifb.sel = 2'd0;
    pc_val = 32'h0;
    for (int k = 0; k < 32; k++) regs[k] = 32'(k);
    for (int k = 0; k < 128; k++) mem[k] = 32'h0;
    mem_b[0] = 16'h1234; mem_b[1] = 16'hABCD; mem_b[2] = 16'h00FF; mem_b[3] = 16'h8001;
    test_reset();
    test_pc_dump();
    test_br_dump();
    test_all_dump();
    test_tx_done_same_cycle();
    test_start_while_busy();
    test_reset_mid_dump();
    test_narrow_no_checksum();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/debug_dump_tx.md
# debug_dump_tx

Parametrised debug-dump transmitter for the debug unit. It streams PC, register-bank and data-memory contents to the UART TX byte interface through a tx_start/tx_done handshake, least-significant byte first. One request can select one source or all three back-to-back, and an XOR checksum byte can be appended. It sits between the debug-unit command FSM (which issues the request) and the UART transmitter, and reads the datapath through a 1-cycle-latency read port.

## Interface
- NB_DATA, 32, word width in bits; must be a multiple of 8; bytes per word NB_BYTES = NB_DATA/8
- N_REGS, 32, register-bank words to dump
- N_MEM, 128, data-memory words to dump
- NB_ADDR, 8, read address width; must satisfy 2^NB_ADDR >= max(N_REGS, N_MEM)
- EN_CHECKSUM, 1, when 1 a checksum byte is appended after the last data byte
- i_clock  in  1  single clock; all logic on its rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle request pulse; sampled only in IDLE
- i_sel  in  2  dump selection: 0 = PC, 1 = BR, 2 = MEM, 3 = ALL (PC, then BR, then MEM)
- o_rd_src  out  2  source being read: 0 = PC, 1 = BR, 2 = MEM
- o_rd_addr  out  NB_ADDR  word index within the source; 0 when o_rd_src = PC
- i_rd_data  in  NB_DATA  read data; valid 1 cycle after o_rd_src/o_rd_addr are presented
- o_tx_start  out  1  one-cycle pulse; o_tx_data is valid in the same cycle
- o_tx_data  out  8  byte to transmit
- i_tx_done_tick  in  1  UART has finished sending the current byte
- o_busy  out  1  high from the cycle after an accepted i_start until the cycle DONE is entered
- o_done  out  1  one-cycle pulse when the dump is complete

## Operation
- FSM states: IDLE, FETCH, LATCH, SEND, WAIT_TX, CKSUM, DONE.
- IDLE:
  - If i_start = 1: latch i_sel and clear the checksum. The first source is PC for sel 0/3, BR for 1, MEM for 2. Clear the word and byte counters, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: drive o_rd_src/o_rd_addr from the current source and word counter, go to LATCH.
- LATCH: register i_rd_data into the word shift register, go to SEND.
- SEND:
  - Assert o_tx_start = 1 with o_tx_data = word[7:0]; XOR that byte into the checksum.
  - Go to WAIT_TX.
- WAIT_TX: wait for i_tx_done_tick, then branch in this order:
  - More bytes in this word (byte counter < NB_BYTES-1): shift the word right by 8, increment the byte counter, go to SEND.
  - Else, more words in this source (word counter < count-1): increment the word counter, go to FETCH. Count is 1 for PC, N_REGS for BR, N_MEM for MEM.
  - Else, sel = 3 and the source is not MEM: advance PC→BR or BR→MEM, clear the word counter, go to FETCH.
  - Otherwise go to CKSUM if EN_CHECKSUM = 1, else DONE.
- CKSUM: pulse o_tx_start with o_tx_data = the accumulated checksum, go to a wait state. On i_tx_done_tick go to DONE. The checksum byte is not folded into itself.
- DONE: pulse o_done = 1, deassert o_busy, go to IDLE.
- Ignored inputs:
  - i_tx_done_tick outside WAIT_TX and the checksum wait, including the cycle o_tx_start is high.
  - i_start outside IDLE.
  - i_sel changes after acceptance.
- Total bytes per dump = words × NB_BYTES + EN_CHECKSUM. With default parameters, ALL = 161 words = 644 bytes + 1.

## Timing
- Reset values: state IDLE, o_tx_start 0, o_tx_data 0, o_busy 0, o_done 0, o_rd_src 0, o_rd_addr 0, counters 0, checksum 0.
- Reset asserted mid-dump: next edge goes to IDLE with all outputs at reset values. No further o_tx_start, no o_done.
- Latency from i_start (edge n):
  - FETCH at n+1, LATCH at n+2.
  - First o_tx_start at n+3.
- Between bytes: i_tx_done_tick seen in WAIT_TX at cycle m gives the next o_tx_start at m+1 within a word, or at m+3 across words (FETCH, LATCH, SEND).
- After the last byte's i_tx_done_tick at cycle m: o_done at m+1 (no checksum), or the checksum o_tx_start at m+1.
- o_tx_data holds its value until the next SEND or CKSUM.
- o_rd_src/o_rd_addr hold from FETCH until the next FETCH.

## Test plan
- PC dump, sel 0, PC source = 0x0000002C, tx_done 100 ns after each start → bytes 2C,00,00,00, then checksum 2C, then o_done. 5 starts total.
- BR dump, sel 1, reg k = k → 128 data bytes ordered k,00,00,00 for k = 0..31, then checksum = XOR of 0..31 = 00. o_rd_addr steps 0..31.
- ALL dump, sel 3, MEM[1] = 0x1E, rest 0, PC = 0x28 → 644 data bytes plus checksum. PC bytes first, MEM word 1 at byte offsets 136–139. Checksum 0x28 ^ 0x1E ^ XOR(0..31) = 0x36.
- EN_CHECKSUM = 0, NB_DATA = 16, sel 2, N_MEM = 4 → exactly 8 o_tx_start pulses, o_done 1 cycle after the 8th tx_done.
- Protocol abuse:
  - tx_done asserted in the same cycle as o_tx_start → ignored, no byte skipped.
  - i_start pulsed while busy → ignored, byte count unchanged.
- Reset mid-dump after the 10th byte of a BR dump → no further o_tx_start, o_busy 0. A subsequent sel 0 request dumps the PC normally.
